// File: rtl/pipelined_row_rotator.sv
// Pipelined row rotator for the transpose datapath.
// Rotates one NUM_PE-word row per beat; one register stage per barrel level
// (L = log2(NUM_PE) stages, latency L), elastic valid/ready on both sides.
//
// Ports:
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid/ready  input handshake; in_ready has no path from in_valid
//   in_row          NUM_PE words, element i moves to (i + r) mod NUM_PE
//   in_shift_amt    explicit rotate amount (ignored when cfg_auto = 1)
//   in_dir          0 = rotate right, 1 = rotate left
//   in_last         end-of-matrix sideband; also clears the row counter
//   cfg_auto        take the amount from the internal row counter
//   out_valid/ready output handshake
//   out_row         rotated row
//   out_last        in_last of this beat
//   out_shift_amt   effective right-rotate amount applied to this beat
module pipelined_row_rotator #(
    parameter  int DATA_WIDTH     = 64,
    parameter  int NUM_PE         = 8,
    localparam int SHIFT_AMT_BITS = $clog2(NUM_PE)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     in_row [0:NUM_PE-1],
    input  logic [SHIFT_AMT_BITS-1:0] in_shift_amt,
    input  logic                      in_dir,
    input  logic                      in_last,
    input  logic                      cfg_auto,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_row [0:NUM_PE-1],
    output logic                      out_last,
    output logic [SHIFT_AMT_BITS-1:0] out_shift_amt
);

    localparam int L = SHIFT_AMT_BITS;

    logic [DATA_WIDTH-1:0]     row_q [L][NUM_PE];
    logic [DATA_WIDTH-1:0]     row_d [L][NUM_PE];
    logic [SHIFT_AMT_BITS-1:0] r_q   [L];
    logic [SHIFT_AMT_BITS-1:0] r_d   [L];
    logic [L-1:0]              v_q, v_d, last_q, last_d, rdy;
    logic [SHIFT_AMT_BITS-1:0] row_cnt, base_amt, r_in;
    logic                      rdy_acc;
    logic                      in_fire;

    // A stage can load if it is empty or any stage downstream of it can move;
    // this lets bubbles collapse while the output is stalled.
    always_comb begin
        rdy     = '0;
        rdy_acc = out_ready;
        for (int unsigned i = 0; i < L; i++) begin
            rdy_acc       = rdy_acc || !v_q[L-1-i];
            rdy[L-1-i]    = rdy_acc;
        end
    end

    assign in_ready = rdy[0];
    assign in_fire  = in_valid && rdy[0];

    // Left rotation by a is expressed as right rotation by -a mod NUM_PE,
    // so every stage only ever rotates right.
    always_comb begin
        base_amt = cfg_auto ? row_cnt : in_shift_amt;
        r_in     = in_dir ? -base_amt : base_amt;
    end

    // Stage k's input: previous stage's contents rotated right by 2^k when r[k] is set.
    always_comb begin
        v_d[0]    = in_valid;
        r_d[0]    = r_in;
        last_d[0] = in_last;
        for (int unsigned j = 0; j < NUM_PE; j++) begin
            row_d[0][j] = r_in[0] ? in_row[SHIFT_AMT_BITS'(j - 32'd1)] : in_row[j];
        end
        for (int unsigned k = 1; k < L; k++) begin
            v_d[k]    = v_q[k-1];
            r_d[k]    = r_q[k-1];
            last_d[k] = last_q[k-1];
            for (int unsigned j = 0; j < NUM_PE; j++) begin
                row_d[k][j] = r_q[k-1][k] ? row_q[k-1][SHIFT_AMT_BITS'(j - (32'd1 << k))]
                                          : row_q[k-1][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            last_q <= '0;
            for (int unsigned k = 0; k < L; k++) begin
                r_q[k] <= '0;
                for (int unsigned j = 0; j < NUM_PE; j++) begin
                    row_q[k][j] <= '0;
                end
            end
        end else begin
            for (int unsigned k = 0; k < L; k++) begin
                if (rdy[k]) begin
                    v_q[k] <= v_d[k];
                    if (v_d[k]) begin
                        r_q[k]    <= r_d[k];
                        last_q[k] <= last_d[k];
                        for (int unsigned j = 0; j < NUM_PE; j++) begin
                            row_q[k][j] <= row_d[k][j];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt <= '0;
        end else if (in_fire && cfg_auto) begin
            if (in_last || row_cnt == SHIFT_AMT_BITS'(NUM_PE - 1)) begin
                row_cnt <= '0;
            end else begin
                row_cnt <= row_cnt + SHIFT_AMT_BITS'(1);
            end
        end
    end

    assign out_valid     = v_q[L-1];
    assign out_last      = last_q[L-1];
    assign out_shift_amt = r_q[L-1];
    assign out_row       = row_q[L-1];

endmodule
